// File: rtl/rr_arb_grant_ctrl_if.sv
// Request/grant bundle between ingress requesters, the grant controller and the PPE.
// The controller takes the master view; the requester/PPE side takes the slave view.
interface rr_arb_grant_ctrl_if #(
    parameter int ARB_WIDTH    = 4,
    parameter int ARB_WIDTH_L2 = $clog2(ARB_WIDTH)
);
    logic [ARB_WIDTH-1:0]    arb_req;
    logic [ARB_WIDTH-1:0]    arb_eop;
    logic                    arb_ready;
    logic [ARB_WIDTH-1:0]    arb_gnt;
    logic [ARB_WIDTH_L2-1:0] arb_gnt_bin;
    logic                    arb_gnt_vld;
    logic                    arb_tout;
    logic [ARB_WIDTH-1:0]    ppe_vec_in;
    logic [ARB_WIDTH_L2-1:0] ppe_priority;
    logic [ARB_WIDTH-1:0]    ppe_vec_out;
    logic [ARB_WIDTH_L2-1:0] ppe_bin_out;

    modport master (
        input  arb_req, arb_eop, arb_ready, ppe_vec_out, ppe_bin_out,
        output arb_gnt, arb_gnt_bin, arb_gnt_vld, arb_tout, ppe_vec_in, ppe_priority
    );

    modport slave (
        output arb_req, arb_eop, arb_ready, ppe_vec_out, ppe_bin_out,
        input  arb_gnt, arb_gnt_bin, arb_gnt_vld, arb_tout, ppe_vec_in, ppe_priority
    );
endinterface

// File: rtl/rr_arb_grant_ctrl.sv
// Round-robin grant controller: captures the PPE winner into a packet-granular held grant
// and rotates the priority pointer past each served port on release.
module rr_arb_grant_ctrl #(
    parameter int ARB_WIDTH    = 4,
    parameter int ARB_WIDTH_L2 = $clog2(ARB_WIDTH),
    parameter int HOLD_MAX     = 64
) (
    input  logic                clk,
    input  logic                rst,
    rr_arb_grant_ctrl_if.master bus
);
    localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;
    localparam logic [ARB_WIDTH_L2-1:0] LAST_PORT = ARB_WIDTH_L2'(ARB_WIDTH - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state_q, state_d;
    logic [ARB_WIDTH-1:0]    gnt_q, gnt_d;
    logic [ARB_WIDTH_L2-1:0] gnt_bin_q, gnt_bin_d;
    logic                    gnt_vld_q, gnt_vld_d;
    logic                    tout_q, tout_d;
    logic [ARB_WIDTH_L2-1:0] prio_q, prio_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic eop_acc;
    logic abort;
    logic tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_bin_q <= '0;
            gnt_vld_q <= 1'b0;
            tout_q    <= 1'b0;
            prio_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_bin_q <= gnt_bin_d;
            gnt_vld_q <= gnt_vld_d;
            tout_q    <= tout_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_bin_d = gnt_bin_q;
        gnt_vld_d = gnt_vld_q;
        tout_d    = 1'b0;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        eop_acc   = 1'b0;
        abort     = 1'b0;
        tmo       = 1'b0;

        case (state_q)
            IDLE: begin
                // An empty PPE vector with live requests is illegal; wait it out in IDLE.
                if (|bus.arb_req && |bus.ppe_vec_out) begin
                    state_d   = GRANT;
                    gnt_d     = bus.ppe_vec_out;
                    gnt_bin_d = bus.ppe_bin_out;
                    gnt_vld_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            GRANT: begin
                eop_acc = bus.arb_req[gnt_bin_q] & bus.arb_eop[gnt_bin_q] & bus.arb_ready;
                abort   = !bus.arb_req[gnt_bin_q];
                tmo     = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);
                if (eop_acc || abort || tmo) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_bin_d = '0;
                    gnt_vld_d = 1'b0;
                    tout_d    = tmo && !eop_acc;
                    // Explicit wrap keeps the pointer legal when ARB_WIDTH is not a power of two.
                    prio_d    = (gnt_bin_q == LAST_PORT) ? '0
                                                         : gnt_bin_q + ARB_WIDTH_L2'(1);
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign bus.arb_gnt      = gnt_q;
    assign bus.arb_gnt_bin  = gnt_bin_q;
    assign bus.arb_gnt_vld  = gnt_vld_q;
    assign bus.arb_tout     = tout_q;
    assign bus.ppe_vec_in   = bus.arb_req;
    assign bus.ppe_priority = prio_q;
endmodule

// File: tb/tb_rr_arb_grant_ctrl.sv
// Directed bench for rr_arb_grant_ctrl: a packet-level reference model scored every cycle,
// plus hand-computed expectations for each scenario.
module tb_rr_arb_grant_ctrl;
    localparam int N    = 4;
    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   ppe_kill = 1'b0;
    bit   chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    int t1_bin [5] = '{0, 1, 2, 3, 0};
    int t1_prio[5] = '{1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    rr_arb_grant_ctrl_if #(.ARB_WIDTH(N)) ifc();

    rr_arb_grant_ctrl #(.ARB_WIDTH(N), .HOLD_MAX(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Ideal PPE: first requester at or after the pointer, searched circularly.
    int pw;
    always_comb begin
        pw = rr_pick(ifc.ppe_vec_in, int'(ifc.ppe_priority));
        ifc.ppe_vec_out = '0;
        ifc.ppe_bin_out = '0;
        if (pw >= 0 && !ppe_kill) begin
            ifc.ppe_vec_out = N'(1) << pw;
            ifc.ppe_bin_out = 2'(pw);
        end
    end

    // Reference model: owner port (-1 = none), cycles held, pointer, timeout flag.
    int m_own = -1;
    int m_held = 0;
    int m_ptr = 0;
    int m_w;
    bit m_tout = 1'b0;
    bit m_eop_ok, m_abort, m_tmo;

    always @(posedge clk) begin
        if (rst) begin
            m_own  = -1;
            m_ptr  = 0;
            m_held = 0;
            m_tout = 1'b0;
        end else begin
            m_tout = 1'b0;
            if (m_own < 0) begin
                m_w = rr_pick(ifc.arb_req, m_ptr);
                if (m_w >= 0 && !ppe_kill) begin
                    m_own  = m_w;
                    m_held = 1;
                end
            end else begin
                m_eop_ok = ifc.arb_req[m_own] && ifc.arb_eop[m_own] && ifc.arb_ready;
                m_abort  = !ifc.arb_req[m_own];
                m_tmo    = (m_held == HOLD);
                if (m_eop_ok || m_abort || m_tmo) begin
                    m_tout = m_tmo && !m_eop_ok;
                    m_ptr  = (m_own + 1) % N;
                    m_own  = -1;
                end else begin
                    m_held++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("vld", ifc.arb_gnt_vld, (m_own >= 0) ? 1 : 0);
            chk("gnt", ifc.arb_gnt, (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
            if (m_own >= 0) chk("gnt_bin", ifc.arb_gnt_bin, m_own);
            chk("tout", ifc.arb_tout, m_tout);
            chk("prio", ifc.ppe_priority, m_ptr);
            chk("vec_in", ifc.ppe_vec_in, ifc.arb_req);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] e, input logic rd);
        ifc.arb_req   = r;
        ifc.arb_eop   = e;
        ifc.arb_ready = rd;
    endtask

    int vcnt, tcnt;

    initial begin
        drive(4'b0000, 4'b0000, 1'b0);
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_vld", ifc.arb_gnt_vld, 0);
        chk("rst_gnt", ifc.arb_gnt, 0);
        chk("rst_tout", ifc.arb_tout, 0);
        chk("rst_prio", ifc.ppe_priority, 0);
        rst = 1'b0;

        // All ports, single-beat packets: strict rotation with a dead cycle between grants.
        drive(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_vld", ifc.arb_gnt_vld, 1);
            chk("t1_bin", ifc.arb_gnt_bin, t1_bin[i]);
            tick();
            chk("t1_rel", ifc.arb_gnt_vld, 0);
            chk("t1_prio", ifc.ppe_priority, t1_prio[i]);
        end
        drive(4'b0000, 4'b0000, 1'b1);
        tick();

        // Pointer wrap from port 3, then port 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(4'b1000, 4'b1000, 1'b1);
        tick();
        chk("t2_bin3", ifc.arb_gnt_bin, 3);
        tick();
        chk("t2_wrap", ifc.ppe_priority, 0);
        drive(4'b0010, 4'b0010, 1'b1);
        tick();
        chk("t2_bin1", ifc.arb_gnt_bin, 1);
        tick();
        chk("t2_prio", ifc.ppe_priority, 2);
        drive(4'b0000, 4'b0000, 1'b1);
        tick();

        // Port 2 never ends its packet: timeout after HOLD cycles.
        drive(4'b0100, 4'b0000, 1'b1);
        vcnt = 0;
        tcnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (ifc.arb_gnt_vld === 1'b1) vcnt++;
            if (ifc.arb_tout === 1'b1) begin
                tcnt++;
                chk("t3_prio", ifc.ppe_priority, 3);
                drive(4'b0000, 4'b0000, 1'b1);
            end
        end
        chk("t3_vld_cycles", vcnt, 8);
        chk("t3_tout_pulses", tcnt, 1);

        // EOP stalled by arb_ready=0 holds the grant.
        drive(4'b0001, 4'b0000, 1'b0);
        tick();
        chk("t4_gnt", ifc.arb_gnt_bin, 0);
        drive(4'b0001, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold", ifc.arb_gnt_vld, 1);
        end
        drive(4'b0001, 4'b0001, 1'b1);
        tick();
        chk("t4_rel", ifc.arb_gnt_vld, 0);
        chk("t4_prio", ifc.ppe_priority, 1);
        chk("t4_tout", ifc.arb_tout, 0);
        drive(4'b0000, 4'b0000, 1'b0);
        tick();

        // Port 1 aborts mid-packet; port 3 follows two cycles after the drop.
        drive(4'b1010, 4'b0000, 1'b1);
        tick();
        chk("t5_bin1", ifc.arb_gnt_bin, 1);
        tick();
        chk("t5_hold", ifc.arb_gnt_vld, 1);
        drive(4'b1000, 4'b0000, 1'b1);
        tick();
        chk("t5_rel", ifc.arb_gnt_vld, 0);
        chk("t5_tout", ifc.arb_tout, 0);
        chk("t5_prio", ifc.ppe_priority, 2);
        tick();
        chk("t5_bin3", ifc.arb_gnt_bin, 3);
        drive(4'b0000, 4'b0000, 1'b1);
        tick();
        chk("t5_prio_wrap", ifc.ppe_priority, 0);
        tick();

        // Reset while port 2 holds the grant.
        drive(4'b0100, 4'b0000, 1'b1);
        tick();
        chk("t6_bin2", ifc.arb_gnt_bin, 2);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_vld", ifc.arb_gnt_vld, 0);
        chk("t6_gnt", ifc.arb_gnt, 0);
        chk("t6_tout", ifc.arb_tout, 0);
        chk("t6_prio", ifc.ppe_priority, 0);
        rst = 1'b0;
        drive(4'b1111, 4'b1111, 1'b1);
        tick();
        chk("t6_rearb", ifc.arb_gnt_bin, 0);
        tick();
        chk("t6_prio1", ifc.ppe_priority, 1);
        drive(4'b0000, 4'b0000, 1'b1);
        tick();

        // PPE reports no winner despite live requests: stay idle.
        ppe_kill = 1'b1;
        drive(4'b0001, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t7_idle", ifc.arb_gnt_vld, 0);
        end
        ppe_kill = 1'b0;
        tick();
        chk("t7_bin0", ifc.arb_gnt_bin, 0);
        drive(4'b0000, 4'b0000, 1'b1);
        tick();
        chk("t7_prio", ifc.ppe_priority, 1);
        tick();

        // EOP on a non-granted port is ignored.
        drive(4'b0011, 4'b0001, 1'b1);
        tick();
        chk("t8_bin1", ifc.arb_gnt_bin, 1);
        tick();
        chk("t8_hold", ifc.arb_gnt_vld, 1);
        drive(4'b0011, 4'b0010, 1'b1);
        tick();
        chk("t8_rel", ifc.arb_gnt_vld, 0);
        chk("t8_prio", ifc.ppe_priority, 2);
        drive(4'b0000, 4'b0000, 1'b1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
